secuenciador_obstaculos: RTL and testbench
==========================================

SECUENCIADOR_OBSTACULOS -- requirements
Module: secuenciador_obstaculos

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port tick, input, 1, one-cycle game-time pulse.
REQ-004 SHALL have port key, input, 5, one-cycle debounced pulses: [0] start, [1] pause toggle, [4] abort; [3:2] unused.
REQ-005 SHALL have port colision, input, 1, one-cycle hero/obstacle collision pulse.
REQ-006 SHALL have port gen_ack, input, 1, obstacle generator accepts the pending spawn.
REQ-007 SHALL have port spawn_req, output, 1, spawn request to the obstacle generator.
REQ-008 SHALL have port spawn_tipo, output, 2, obstacle type for the current request, equal to mundo.
REQ-009 SHALL have port mundo, output, 2, current world 0..3.
REQ-010 SHALL have port progreso, output, 5, accepted spawns in the current world, 0..31.
REQ-011 SHALL have port conteo_obs, output, 7, tick counter toward the next spawn.
REQ-012 SHALL have port condicion, output, 1, sticky overrun flag.
REQ-013 SHALL have port estado, output, 3, FSM state code.

Function
REQ-014 SHALL implement FSM states INACTIVO=0, JUGANDO=1, PAUSA=2, GANADO=3, PERDIDO=4.
REQ-015 INACTIVO/GANADO/PERDIDO + key[0] SHALL go to JUGANDO next cycle and clear mundo, progreso, conteo_obs, condicion and spawn_req.
REQ-016 JUGANDO + key[1] SHALL go to PAUSA; PAUSA + key[1] SHALL return to JUGANDO; key[0] SHALL be ignored in JUGANDO and PAUSA.
REQ-017 key[4] in any state SHALL force INACTIVO with the same clears as REQ-015, with priority over all other inputs.
REQ-018 In JUGANDO only, each tick SHALL increment conteo_obs; when conteo_obs = PERIODO[mundo]-1 it SHALL wrap to 0 and spawn_req SHALL be 1 from the next cycle.
REQ-019 PERIODO SHALL be 96, 80, 64, 48 ticks for mundo 0, 1, 2, 3.
REQ-020 spawn_req SHALL stay high, with spawn_tipo stable, until the cycle gen_ack=1; it SHALL deassert the following cycle.
REQ-021 gen_ack while spawn_req=0 SHALL be ignored.
REQ-022 A wrap while spawn_req is still pending SHALL set condicion=1 and SHALL NOT queue a second request.
REQ-023 condicion SHALL clear only on rst, key[0] start or key[4].
REQ-024 Each accepted spawn (spawn_req & gen_ack) in JUGANDO SHALL increment progreso.
REQ-025 At progreso=31 with mundo<3, an accepted spawn SHALL set progreso=0, increment mundo and reset conteo_obs to 0.
REQ-026 At progreso=31 with mundo=3, an accepted spawn SHALL go to GANADO.
REQ-027 colision in JUGANDO SHALL go to PERDIDO; if gen_ack occurs in the same cycle, colision SHALL win and progreso SHALL be unchanged.
REQ-028 In PAUSA, conteo_obs, progreso and mundo SHALL be frozen; spawn_req SHALL be held; gen_ack SHALL be ignored; colision SHALL be ignored.
REQ-029 On entry to GANADO or PERDIDO, spawn_req SHALL drop; outputs other than estado and spawn_req SHALL hold until start.
REQ-030 tick and gen_ack in the same cycle SHALL both take effect.
REQ-031 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-032 rst=1 SHALL force estado=INACTIVO, spawn_req=0, spawn_tipo=0, mundo=0, progreso=0, conteo_obs=0, condicion=0 on the next edge.
REQ-033 rst SHALL take priority over all inputs, including during a pending spawn.
REQ-034 No outputs SHALL change in the cycle after rst deasserts unless inputs demand it.

Structure
REQ-035 A shared package heroe_pkg SHALL hold the state enum/codes, PERIODO table, MUNDO_MAX=3 and PROGRESO_MAX=31.
REQ-036 Sub-module temporizador_spawn SHALL contain conteo_obs plus the wrap/enable logic; the FSM and handshake SHALL remain at top level.
REQ-037 Ports mundo, progreso, conteo_obs, condicion and key SHALL keep these exact names for the on-chip logic analyzer.

Verification
REQ-038 rst, key[0], 96 ticks, gen_ack 2 cycles later -> spawn_req high 3 cycles; progreso=1; conteo_obs=0.
REQ-039 Play through with immediate acks, 32 spawns -> mundo=1, progreso=0; next spawn after 80 ticks.
REQ-040 Withhold gen_ack for 96 ticks after a request -> condicion=1, single request only; after ack, progreso=1.
REQ-041 key[1], 200 ticks, key[1] -> conteo_obs, progreso and mundo unchanged across the pause.
REQ-042 colision and gen_ack in the same cycle -> estado=4, spawn_req=0 next cycle, progreso unchanged; key[0] -> estado=1 with all cleared.
REQ-043 mundo=3, progreso=31, ack -> estado=3; rst mid-request -> all outputs 0 next cycle.

Source files
------------

// File: rtl/heroe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : heroe_pkg
// Purpose  : Shared state codes, spawn period table and game limits for the
//            obstacle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package heroe_pkg;

  typedef enum logic [2:0] {
    INACTIVO = 3'd0,
    JUGANDO  = 3'd1,
    PAUSA    = 3'd2,
    GANADO   = 3'd3,
    PERDIDO  = 3'd4
  } estado_t;

  // Ticks between spawns, indexed by world; entry 0 is the rightmost element.
  localparam logic [3:0][6:0] PERIODO = {7'd48, 7'd64, 7'd80, 7'd96};

  localparam logic [1:0] MUNDO_MAX    = 2'd3;
  localparam logic [4:0] PROGRESO_MAX = 5'd31;

  // Last counter value before the spawn counter wraps in a given world.
  function automatic logic [6:0] ultimo_conteo(input logic [1:0] mundo);
    return PERIODO[mundo] - 7'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/temporizador_spawn.sv
`default_nettype none
// ============================================================================
// Module   : temporizador_spawn
// Purpose  : Tick counter toward the next obstacle spawn; produces a one-cycle
//            wrap strobe when the current world's period elapses.
// Revision : 1.0 - initial release
// ============================================================================
module temporizador_spawn
  import heroe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [1:0] mundo_i,
  output logic [6:0] conteo_o,
  output logic       wrap_o
);

  logic [6:0] conteo_q;
  logic [6:0] conteo_d;

  // Next count: clear wins, then wrap at end of period, else count enabled ticks.
  always_comb begin
    wrap_o   = en_i && (conteo_q == ultimo_conteo(mundo_i));
    conteo_d = conteo_q;
    if (clr_i) begin
      conteo_d = '0;
    end else if (wrap_o) begin
      conteo_d = '0;
    end else if (en_i) begin
      conteo_d = conteo_q + 7'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      conteo_q <= '0;
    end else begin
      conteo_q <= conteo_d;
    end
  end

  assign conteo_o = conteo_q;

endmodule
`default_nettype wire

// File: rtl/secuenciador_obstaculos.sv
`default_nettype none
// ============================================================================
// Module   : secuenciador_obstaculos
// Purpose  : Game sequencer: play/pause/win/lose FSM, spawn request handshake
//            with the obstacle generator, world and progress tracking.
// Revision : 1.0 - initial release
// ============================================================================
module secuenciador_obstaculos
  import heroe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [4:0] key,
  input  logic       colision,
  input  logic       gen_ack,
  output logic       spawn_req,
  output logic [1:0] spawn_tipo,
  output logic [1:0] mundo,
  output logic [4:0] progreso,
  output logic [6:0] conteo_obs,
  output logic       condicion,
  output logic [2:0] estado
);

  estado_t    estado_q;
  logic       spawn_req_q;
  logic [1:0] spawn_tipo_q;
  logic [1:0] mundo_q;
  logic [4:0] progreso_q;
  logic       condicion_q;

  logic abortar;
  logic arrancar;
  logic activo;
  logic acepta;
  logic ultimo;
  logic gana;
  logic avanza;
  logic temp_en;
  logic temp_clr;
  logic temp_wrap;
  logic unused_keys;

  // Keys 2 and 3 carry no function.
  assign unused_keys = ^key[3:2];

  assign abortar  = key[4];
  assign arrancar = !key[4] && key[0] &&
                    ((estado_q == INACTIVO) || (estado_q == GANADO) ||
                     (estado_q == PERDIDO));
  // Playing this cycle and not overridden by abort or a collision.
  assign activo   = (estado_q == JUGANDO) && !abortar && !colision;
  assign acepta   = activo && spawn_req_q && gen_ack;
  assign ultimo   = (progreso_q == PROGRESO_MAX);
  assign gana     = acepta && ultimo && (mundo_q == MUNDO_MAX);
  assign avanza   = acepta && ultimo && (mundo_q != MUNDO_MAX);
  // Counter freezes on the winning spawn so the final count stays visible.
  assign temp_en  = activo && tick && !gana;
  assign temp_clr = abortar || arrancar || avanza;

  temporizador_spawn u_temporizador (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (temp_clr),
    .en_i     (temp_en),
    .mundo_i  (mundo_q),
    .conteo_o (conteo_obs),
    .wrap_o   (temp_wrap)
  );

  // Game FSM with the spawn handshake and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst || abortar) begin
      estado_q     <= INACTIVO;
      spawn_req_q  <= 1'b0;
      spawn_tipo_q <= 2'd0;
      mundo_q      <= 2'd0;
      progreso_q   <= 5'd0;
      condicion_q  <= 1'b0;
    end else begin
      case (estado_q)
        INACTIVO, GANADO, PERDIDO: begin
          if (key[0]) begin
            estado_q     <= JUGANDO;
            spawn_req_q  <= 1'b0;
            spawn_tipo_q <= 2'd0;
            mundo_q      <= 2'd0;
            progreso_q   <= 5'd0;
            condicion_q  <= 1'b0;
          end
        end
        JUGANDO: begin
          if (colision) begin
            estado_q    <= PERDIDO;
            spawn_req_q <= 1'b0;
          end else begin
            if (key[1]) begin
              estado_q <= PAUSA;
            end
            // A wrap that finds an unacknowledged request is an overrun.
            if (temp_wrap && spawn_req_q && !gen_ack) begin
              condicion_q <= 1'b1;
            end
            if (temp_wrap) begin
              spawn_req_q <= 1'b1;
            end else if (acepta) begin
              spawn_req_q <= 1'b0;
            end
            if (acepta) begin
              if (!ultimo) begin
                progreso_q <= progreso_q + 5'd1;
              end else if (gana) begin
                estado_q    <= GANADO;
                spawn_req_q <= 1'b0;
              end else begin
                progreso_q   <= 5'd0;
                mundo_q      <= mundo_q + 2'd1;
                spawn_tipo_q <= mundo_q + 2'd1;
              end
            end
          end
        end
        PAUSA: begin
          if (key[1]) begin
            estado_q <= JUGANDO;
          end
        end
        default: begin
          estado_q <= INACTIVO;
        end
      endcase
    end
  end

  assign spawn_req  = spawn_req_q;
  assign spawn_tipo = spawn_tipo_q;
  assign mundo      = mundo_q;
  assign progreso   = progreso_q;
  assign condicion  = condicion_q;
  assign estado     = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_obstaculos.sv
`default_nettype none
// ============================================================================
// Module   : tb_secuenciador_obstaculos
// Purpose  : Directed scoreboard bench for the obstacle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_secuenciador_obstaculos;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [4:0] key;
  logic       colision;
  logic       gen_ack;
  logic       spawn_req;
  logic [1:0] spawn_tipo;
  logic [1:0] mundo;
  logic [4:0] progreso;
  logic [6:0] conteo_obs;
  logic       condicion;
  logic [2:0] estado;

  secuenciador_obstaculos dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .key        (key),
    .colision   (colision),
    .gen_ack    (gen_ack),
    .spawn_req  (spawn_req),
    .spawn_tipo (spawn_tipo),
    .mundo      (mundo),
    .progreso   (progreso),
    .conteo_obs (conteo_obs),
    .condicion  (condicion),
    .estado     (estado)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] e;
    logic       s;
    logic [1:0] t;
    logic [1:0] m;
    logic [4:0] p;
    logic [6:0] c;
    logic       k;
  } snap_t;

  typedef struct {
    logic [1:0] m;
    logic [4:0] p;
  } spawn_t;

  snap_t  q_snap[$];
  spawn_t q_spawn[$];
  snap_t  cur;
  spawn_t cur_sp;
  int     n_checks = 0;
  int     n_fail   = 0;
  logic   spawn_prev = 1'b0;
  logic   done = 1'b0;

  // Independent model of the game progress
  int per_tb[4] = '{96, 80, 64, 48};
  int m_mod, p_mod, c_mod;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input string nm, input int e, input int s, input int t,
                      input int m, input int p, input int c, input int k);
    snap_t x;
    x.name = nm; x.e = 3'(e); x.s = 1'(s); x.t = 2'(t);
    x.m = 2'(m); x.p = 5'(p); x.c = 7'(c); x.k = 1'(k);
    q_snap.push_back(x);
  endtask

  task automatic exp_spawn(input int m, input int p);
    spawn_t x;
    x.m = 2'(m); x.p = 5'(p);
    q_spawn.push_back(x);
  endtask

  task automatic pulse_key(input int idx);
    key = 5'd0;
    key[idx] = 1'b1;
    cyc();
    key = 5'd0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  // One full spawn period, then an immediate ack with a concurrent tick.
  task automatic play_one();
    exp_spawn(m_mod, p_mod);
    ticks(per_tb[m_mod] - c_mod);
    c_mod = 0;
    gen_ack = 1'b1;
    tick = 1'b1;
    cyc();
    gen_ack = 1'b0;
    tick = 1'b0;
    if (p_mod == 31) begin
      if (m_mod != 3) begin
        m_mod = m_mod + 1;
        p_mod = 0;
      end
    end else begin
      p_mod = p_mod + 1;
      c_mod = 1;
    end
  endtask

  // Monitor: pops expected snapshots and spawn requests and compares them.
  always @(negedge clk) begin
    if (q_snap.size() > 0) begin
      cur = q_snap.pop_front();
      n_checks++;
      if ({estado, spawn_req, spawn_tipo, mundo, progreso, conteo_obs, condicion} !==
          {cur.e, cur.s, cur.t, cur.m, cur.p, cur.c, cur.k}) begin
        n_fail++;
        $display("FAIL %s: got estado=%0d req=%0d tipo=%0d mundo=%0d prog=%0d conteo=%0d cond=%0d, want estado=%0d req=%0d tipo=%0d mundo=%0d prog=%0d conteo=%0d cond=%0d",
                 cur.name, estado, spawn_req, spawn_tipo, mundo, progreso, conteo_obs, condicion,
                 cur.e, cur.s, cur.t, cur.m, cur.p, cur.c, cur.k);
      end
    end
    if (spawn_req === 1'b1 && spawn_prev !== 1'b1) begin
      n_checks++;
      if (q_spawn.size() == 0) begin
        n_fail++;
        $display("FAIL spawn_unexpected: got request tipo=%0d mundo=%0d prog=%0d, want none",
                 spawn_tipo, mundo, progreso);
      end else begin
        cur_sp = q_spawn.pop_front();
        if ({spawn_tipo, mundo, progreso, conteo_obs} !== {cur_sp.m, cur_sp.m, cur_sp.p, 7'd0}) begin
          n_fail++;
          $display("FAIL spawn_fields: got tipo=%0d mundo=%0d prog=%0d conteo=%0d, want tipo=%0d mundo=%0d prog=%0d conteo=0",
                   spawn_tipo, mundo, progreso, conteo_obs, cur_sp.m, cur_sp.m, cur_sp.p);
        end
      end
    end
    spawn_prev = spawn_req;
    if (done) begin
      n_checks++;
      if (q_snap.size() != 0 || q_spawn.size() != 0) begin
        n_fail++;
        $display("FAIL queues_drained: got snap=%0d spawn=%0d pending, want 0 and 0",
                 q_snap.size(), q_spawn.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; key = 5'd0; colision = 1'b0; gen_ack = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    snap("reset", 0, 0, 0, 0, 0, 0, 0); cyc();
    snap("idle_hold", 0, 0, 0, 0, 0, 0, 0); cyc();

    // First spawn, acked in the third request cycle
    pulse_key(0);
    snap("start", 1, 0, 0, 0, 0, 0, 0); cyc();
    exp_spawn(0, 0);
    ticks(95);
    snap("pre_wrap", 1, 0, 0, 0, 0, 95, 0); cyc();
    ticks(1);
    snap("req_cycle1", 1, 1, 0, 0, 0, 0, 0); cyc();
    snap("req_cycle2", 1, 1, 0, 0, 0, 0, 0); cyc();
    gen_ack = 1'b1;
    snap("req_cycle3", 1, 1, 0, 0, 0, 0, 0); cyc();
    gen_ack = 1'b0;
    snap("first_ack", 1, 0, 0, 0, 1, 0, 0); cyc();

    // Finish world 0 and check world 1 period
    m_mod = 0; p_mod = 1; c_mod = 0;
    repeat (31) play_one();
    snap("world1", 1, 0, 1, 1, 0, 0, 0); cyc();
    ticks(79);
    snap("w1_pre_wrap", 1, 0, 1, 1, 0, 79, 0); cyc();
    exp_spawn(1, 0);
    ticks(1);
    snap("w1_req", 1, 1, 1, 1, 0, 0, 0);
    gen_ack = 1'b1; cyc(); gen_ack = 1'b0;
    snap("w1_ack", 1, 0, 1, 1, 1, 0, 0); cyc();

    // Abort clears everything
    pulse_key(4);
    snap("abort", 0, 0, 0, 0, 0, 0, 0); cyc();

    // Overrun
    pulse_key(0);
    exp_spawn(0, 0);
    ticks(96);
    snap("ov_req", 1, 1, 0, 0, 0, 0, 0); cyc();
    ticks(96);
    snap("overrun", 1, 1, 0, 0, 0, 0, 1);
    gen_ack = 1'b1; cyc(); gen_ack = 1'b0;
    snap("ov_ack", 1, 0, 0, 0, 1, 0, 1); cyc();
    gen_ack = 1'b1; cyc(); gen_ack = 1'b0;
    snap("stray_ack", 1, 0, 0, 0, 1, 0, 1); cyc();
    pulse_key(0);
    snap("start_ignored", 1, 0, 0, 0, 1, 0, 1); cyc();

    // Pause freezes everything
    ticks(10);
    pulse_key(1);
    snap("paused", 2, 0, 0, 0, 1, 10, 1); cyc();
    for (int i = 0; i < 200; i++) begin
      tick = 1'b1;
      gen_ack = (i == 50);
      colision = (i == 100);
      key[0] = (i == 150);
      cyc();
    end
    tick = 1'b0; gen_ack = 1'b0; colision = 1'b0; key = 5'd0;
    snap("pause_frozen", 2, 0, 0, 0, 1, 10, 1); cyc();
    pulse_key(1);
    snap("resumed", 1, 0, 0, 0, 1, 10, 1); cyc();

    // Collision beats a simultaneous ack
    exp_spawn(0, 1);
    ticks(86);
    snap("pre_collision", 1, 1, 0, 0, 1, 0, 1);
    colision = 1'b1; gen_ack = 1'b1; cyc(); colision = 1'b0; gen_ack = 1'b0;
    snap("lost", 4, 0, 0, 0, 1, 0, 1); cyc();
    ticks(5);
    gen_ack = 1'b1; cyc(); gen_ack = 1'b0;
    snap("lost_hold", 4, 0, 0, 0, 1, 0, 1); cyc();
    pulse_key(0);
    snap("restart", 1, 0, 0, 0, 0, 0, 0); cyc();

    // Play through all worlds to the win
    m_mod = 0; p_mod = 0; c_mod = 0;
    repeat (127) play_one();
    snap("last_world", 1, 0, 3, 3, 31, 1, 0); cyc();
    play_one();
    snap("won", 3, 0, 3, 3, 31, 0, 0); cyc();
    pulse_key(1);
    ticks(5);
    snap("won_hold", 3, 0, 3, 3, 31, 0, 0); cyc();

    // Reset during a pending request
    pulse_key(0);
    exp_spawn(0, 0);
    ticks(96);
    snap("req_before_rst", 1, 1, 0, 0, 0, 0, 0);
    rst = 1'b1; gen_ack = 1'b1; tick = 1'b1; cyc();
    rst = 1'b0; gen_ack = 1'b0; tick = 1'b0;
    snap("rst_mid_req", 0, 0, 0, 0, 0, 0, 0); cyc();
    snap("post_rst", 0, 0, 0, 0, 0, 0, 0); cyc();
    done = 1'b1;
  end

endmodule
`default_nettype wire
